// File: rtl/touch_panel_pio_in_if.sv
// rtl/touch_panel_pio_in_if.sv - Avalon-MM register bus and interrupt line for touch_panel_pio_in
interface touch_panel_pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/touch_panel_pio_in.sv
// rtl/touch_panel_pio_in.sv - WIDTH-bit synchronised input PIO with W1C edge capture and maskable irq
// Optional per-bit debounce filter is compiled in with TOUCH_PIO_DEBOUNCE_EN.
module touch_panel_pio_in #(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      in_port,
    touch_panel_pio_in_if.slave   bus
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] s_w;
    logic [WIDTH-1:0] f_w;

    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign s_w = sync_q[SYNC_STAGES-1];

`ifdef TOUCH_PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;

    // A bit only follows s once it has disagreed with stable for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s_w[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s_w[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign f_w = stable_q;
`else
    assign f_w = s_w;
`endif

    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] rise_w, fall_w, edge_w, clr_w, wdata_w;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata_w      = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        rise_w = f_w & ~prev_q;
        fall_w = ~f_w & prev_q;
        if (EDGE_TYPE == 0) begin
            edge_w = rise_w;
        end else if (EDGE_TYPE == 1) begin
            edge_w = fall_w;
        end else begin
            edge_w = rise_w | fall_w;
        end
    end

    // Set is OR-ed in after the clear so a coincident edge survives the W1C write.
    always_comb begin
        prev_d         = f_w;
        clr_w          = (wr_en && bus.address == 2'd3) ? wdata_w : '0;
        edge_capture_d = (edge_capture_q & ~clr_w) | edge_w;
        irq_mask_d     = (wr_en && bus.address == 2'd2) ? wdata_w : irq_mask_q;
    end

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            2'd0:    readdata_d[WIDTH-1:0] = f_w;
            2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q         <= '0;
            edge_capture_q <= '0;
            irq_mask_q     <= '0;
            readdata_q     <= '0;
        end else begin
            prev_q         <= prev_d;
            edge_capture_q <= edge_capture_d;
            irq_mask_q     <= irq_mask_d;
            readdata_q     <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_touch_panel_pio_in.sv
// tb/tb_touch_panel_pio_in.sv - self-checking bench for touch_panel_pio_in (rising and any-edge instances)
module tb_touch_panel_pio_in;
    localparam int W  = 4;
    localparam int SS = 2;
    localparam int DC = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port = '0;

    touch_panel_pio_in_if bus0();
    touch_panel_pio_in_if bus1();

    touch_panel_pio_in #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DC)) u_rise (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus0));
    touch_panel_pio_in #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DC)) u_any (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus1));

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] hist[$];
    logic [W-1:0] prev_m;
    logic [W-1:0] stable_m;
    int           run_m [W];
    logic [W-1:0] cap_m  [2];
    logic [W-1:0] mask_m [2];
    logic [31:0]  rd_m   [2];
    int           et     [2] = '{0, 2};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_bus(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        bus0.address = a; bus0.chipselect = cs; bus0.write_n = wn; bus0.writedata = wd;
        bus1.address = a; bus1.chipselect = cs; bus1.write_n = wn; bus1.writedata = wd;
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SS; i++) hist.push_back('0);
        prev_m = '0;
        stable_m = '0;
        for (int i = 0; i < W; i++) run_m[i] = 0;
        for (int k = 0; k < 2; k++) begin
            cap_m[k] = '0; mask_m[k] = '0; rd_m[k] = '0;
        end
    endtask

    function automatic logic [W-1:0] cur_f();
`ifdef TOUCH_PIO_DEBOUNCE_EN
        return stable_m;
`else
        return hist[0];
`endif
    endfunction

    function automatic logic [W-1:0] edges(input int t, input logic [W-1:0] f, input logic [W-1:0] p);
        if (t == 0) return f & ~p;
        if (t == 1) return ~f & p;
        return f ^ p;
    endfunction

    task automatic check_all();
        check("rd_rise",  bus0.readdata, rd_m[0]);
        check("rd_any",   bus1.readdata, rd_m[1]);
        check("irq_rise", {31'b0, bus0.irq}, {31'b0, |(cap_m[0] & mask_m[0])});
        check("irq_any",  {31'b0, bus1.irq}, {31'b0, |(cap_m[1] & mask_m[1])});
    endtask

    // One clock: advance the reference model with the inputs the DUT is about to see, then compare.
    task automatic tick();
        logic [W-1:0] f, s, clr, wd;
        logic [1:0]   a;
        logic         wr;
        f  = cur_f();
        s  = hist[0];
        a  = bus0.address;
        wd = bus0.writedata[W-1:0];
        wr = bus0.chipselect && !bus0.write_n;
        for (int k = 0; k < 2; k++) begin
            case (a)
                2'd0:    rd_m[k] = {{(32-W){1'b0}}, f};
                2'd2:    rd_m[k] = {{(32-W){1'b0}}, mask_m[k]};
                2'd3:    rd_m[k] = {{(32-W){1'b0}}, cap_m[k]};
                default: rd_m[k] = '0;
            endcase
            clr = (wr && a == 2'd3) ? wd : '0;
            cap_m[k] = (cap_m[k] & ~clr) | edges(et[k], f, prev_m);
            if (wr && a == 2'd2) mask_m[k] = wd;
        end
        prev_m = f;
        for (int i = 0; i < W; i++) begin
            if (s[i] != stable_m[i]) begin
                run_m[i] = run_m[i] + 1;
                if (run_m[i] == DC) begin
                    stable_m[i] = s[i];
                    run_m[i] = 0;
                end
            end else begin
                run_m[i] = 0;
            end
        end
        hist.push_back(in_port);
        void'(hist.pop_front());
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] wd);
        set_bus(a, 1'b1, 1'b0, wd);
        tick();
        set_bus(a, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic hard_reset();
        reset_n = 1'b0;
        #1;
        check("rst_rd_rise",  bus0.readdata, 32'h0);
        check("rst_irq_rise", {31'b0, bus0.irq}, 32'h0);
        check("rst_rd_any",   bus1.readdata, 32'h0);
        check("rst_irq_any",  {31'b0, bus1.irq}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        set_bus(2'd0, 1'b0, 1'b1, 32'h0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rd", bus0.readdata, 32'h0);
        check("reset_irq", {31'b0, bus0.irq}, 32'h0);
        reset_n = 1'b1;
        tick();
        check("addr0_idle", bus0.readdata, 32'h0);

`ifdef TOUCH_PIO_DEBOUNCE_EN
        do_write(2'd2, 32'hF);
        in_port = 4'h8;
        ticks(10);
        in_port = 4'h0;
        set_bus(2'd3, 1'b0, 1'b1, 32'h0);
        ticks(30);
        check("db_short_cap", bus0.readdata, 32'h0);
        set_bus(2'd0, 1'b0, 1'b1, 32'h0);
        tick();
        check("db_short_f", bus0.readdata, 32'h0);
        in_port = 4'h8;
        ticks(25);
        check("db_long_f", bus0.readdata, 32'h8);
        set_bus(2'd3, 1'b0, 1'b1, 32'h0);
        tick();
        check("db_long_cap", bus0.readdata, 32'h8);
        check("db_long_irq", {31'b0, bus0.irq}, 32'h1);
        in_port = 4'h0;
        ticks(8);
        hard_reset();
        in_port = 4'h0;
        set_bus(2'd0, 1'b0, 1'b1, 32'h0);
        ticks(SS + DC + 4);
`endif

        in_port = 4'h5;
        ticks(SS);
        check("lat_before", bus0.readdata, 32'h0);
        tick();
        check("lat_addr0", bus0.readdata, 32'h5);
        set_bus(2'd3, 1'b0, 1'b1, 32'h0);
        ticks(DC + 2);
        check("cap_0x5", bus0.readdata, 32'h5);
        check("irq_unmasked", {31'b0, bus0.irq}, 32'h0);

        do_write(2'd2, 32'h4);
        do_write(2'd3, 32'h4);
        check("irq_after_clr2", {31'b0, bus0.irq}, 32'h0);
        in_port = 4'h1;
        ticks(DC + 4);
        in_port = 4'h5;
        ticks(DC + 4);
        check("irq_bit2", {31'b0, bus0.irq}, 32'h1);
        do_write(2'd3, 32'h4);
        check("irq_cleared", {31'b0, bus0.irq}, 32'h0);
        set_bus(2'd3, 1'b0, 1'b1, 32'h0);
        tick();
        check("bit0_remains", bus0.readdata, 32'h1);

`ifndef TOUCH_PIO_DEBOUNCE_EN
        in_port = 4'h7;
        ticks(SS);
        do_write(2'd3, 32'h2);
        set_bus(2'd3, 1'b0, 1'b1, 32'h0);
        tick();
        check("set_wins", {31'b0, bus0.readdata[1]}, 32'h1);
`endif

        in_port = 4'h7;
        ticks(DC + 4);
        do_write(2'd3, 32'hF);
        in_port = 4'h6;
        ticks(DC + 4);
        do_write(2'd3, 32'hF);
        in_port = 4'h7;
        ticks(DC + 4);
        set_bus(2'd3, 1'b0, 1'b1, 32'h0);
        tick();
        check("any_rise", {31'b0, bus1.readdata[0]}, 32'h1);
        do_write(2'd3, 32'h1);
        in_port = 4'h6;
        ticks(DC + 4);
        set_bus(2'd3, 1'b0, 1'b1, 32'h0);
        tick();
        check("any_fall", {31'b0, bus1.readdata[0]}, 32'h1);
        check("rise_no_fall", {31'b0, bus0.readdata[0]}, 32'h0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
            if ($urandom_range(0, 3) == 0)
                set_bus(2'($urandom), 1'b1, 1'b0, $urandom);
            else
                set_bus(2'($urandom), 1'($urandom_range(0, 1)), 1'b1, $urandom);
            tick();
        end

        do_write(2'd2, 32'hF);
        in_port = ~in_port;
        ticks(SS + DC + 2);
        check("irq_pre_reset", {31'b0, bus1.irq}, 32'h1);
        hard_reset();
        set_bus(2'd3, 1'b0, 1'b1, 32'h0);
        ticks(SS + DC + 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/touch_panel_pio_in.md
Name: touch_panel_pio_in

Overview:
Parametrised successor to the 1-bit touch-panel input PIO. It samples a WIDTH-bit external input bus through a synchroniser and detects edges per bit. Edges are latched into a write-1-to-clear capture register, which drives a maskable interrupt. The block is an Avalon-MM slave on the Nios bus, so software can poll the panel BUSY/PENIRQ lines or take an interrupt instead of busy-waiting.

Parameters:
WIDTH, 1, number of input bits (1..32).
SYNC_STAGES, 2, flip-flop stages in the input synchroniser (>=2).
EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any.
DEBOUNCE_CYCLES, 16, stable-cycle count for the debounce filter; used only with TOUCH_PIO_DEBOUNCE_EN.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
address  in  2  word address: 0 data, 2 irq mask, 3 edge capture.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe, qualified by chipselect.
writedata  in  32  write data; bits [WIDTH-1:0] used.
in_port  in  WIDTH  asynchronous external inputs.
readdata  out  32  registered read data.
irq  out  1  interrupt, high while any unmasked capture bit is set.

Behaviour:
- Reset (async, reset_n=0): all synchroniser flops, prev, edge_capture, irq_mask, readdata = 0; the debounce state, when compiled in, also = 0. irq = 0.
- Synchroniser: SYNC_STAGES-deep shift per bit; s = last stage. Without debounce, filtered value f = s.
- Edge detect: prev <= f each cycle.
  - rise = f & ~prev; fall = ~f & prev.
  - edge = rise, fall, or rise|fall per EDGE_TYPE.
- Held-high input out of reset: one rising edge is seen; capture bit sets on cycle SYNC_STAGES+1 after reset release. This is intended behaviour.
- edge_capture[i]:
  - Set by edge[i].
  - Cleared by a write to address 3 with chipselect=1, write_n=0, writedata[i]=1.
  - Same-cycle set and clear: set wins, bit stays 1.
  - Bits written 0 are unaffected.
- irq_mask: written whole from writedata[WIDTH-1:0] on a write to address 2. Writes to addresses 0 and 1 are ignored.
- irq = |(edge_capture & irq_mask). Combinational from registers, so it is glitch-free relative to clk.
- readdata: updated every clk, no read strobe, 1-cycle latency from address.
  - addr 0: f, zero-extended.
  - addr 1: 0.
  - addr 2: irq_mask.
  - addr 3: edge_capture.
  - Upper 32-WIDTH bits are always 0.
- Write and read to the same register in one cycle: readdata shows the pre-write value. The new value appears one cycle later.
- Reset mid-operation: all state clears immediately. Captured edges are lost, irq drops asynchronously.
- Total in_port-to-readdata latency (addr 0): SYNC_STAGES+1 cycles.

Optional Feature:
Macro: TOUCH_PIO_DEBOUNCE_EN.
- Defined: per-bit counter of width $clog2(DEBOUNCE_CYCLES+1) and a stable register, with f = stable.
  - When s != stable, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while s != stable, stable <= s and the counter clears.
  - When s == stable, the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES produce no change in f and no edge.
  - Latency adds DEBOUNCE_CYCLES cycles.
- Not defined: no counter or stable logic is generated; f = s directly; DEBOUNCE_CYCLES is ignored.

Test Plan:
1. Reset with in_port=0, then read address 0 -> readdata=0x0; irq=0.
2. WIDTH=4, EDGE_TYPE=0, in_port 0x0 -> 0x5 -> readdata at addr 0 = 0x5 after SYNC_STAGES+1 cycles; addr 3 reads 0x5; irq=0 with mask 0.
3. Write mask 0x4, then in_port bit 2 rises -> irq=1. Write 0x4 to addr 3 -> capture bit 2 clears, irq=0 next cycle, bit 0 remains.
4. Arrange a new rising edge on bit 1 in the same cycle as a clear write of 0x2 to addr 3 -> addr 3 still reads bit 1 = 1.
5. EDGE_TYPE=2: toggle bit 0 high then low, clearing between toggles -> capture sets on both transitions.
6. With TOUCH_PIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=16:
   - a 10-cycle high pulse gives no capture and addr 0 stays 0;
   - a 20-cycle high level gives capture bit set and addr 0 = 1.
   - Assert reset_n=0 mid-count -> all registers 0, irq=0 immediately.
